sipo_frame_ctrl: RTL and testbench
==================================

# sipo_frame_ctrl

Controller for the serial-in/parallel-out capture path: accepts a framed serial bit stream over a valid/ready handshake and sequences a WIDTH-bit shift chain. Presents each completed word on a parallel output with its own valid/ready handshake, and back-pressures the serial side while a word is held. Sits between a serial front end (line receiver, bit sampler) and any parallel consumer. Optional parity checking is compiled in by macro.

## Interface
- `WIDTH`, default 4: data bits per frame; legal range 2..32.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `s_valid`  in  1: serial bit valid.
- `s_data`  in  1: serial bit value.
- `s_first`  in  1: qualifies `s_data` as the first bit of a frame; meaningful only while `s_valid`=1.
- `s_ready`  out  1: controller accepts a bit this cycle.
- `p_data`  out  WIDTH: assembled word.
- `p_valid`  out  1: `p_data`/`p_err` hold a complete frame.
- `p_ready`  in  1: consumer accepts the word.
- `p_err`  out  1: parity mismatch for the held word; constant 0 without the parity feature.
- `frame_drop`  out  1: one-cycle pulse when a partial frame is discarded by resync.
- `busy`  out  1: high in SHIFT, PAR or HOLD.

## Operation
- Bit accept: a bit is accepted when `s_valid && s_ready` at a rising edge.
- Shift rule: `shreg <= {shreg[WIDTH-2:0], s_data}`. The first bit of a frame ends in `p_data[WIDTH-1]` and the last in `p_data[0]`.
- Bit counter: `cnt` is $clog2(WIDTH+1) bits wide and counts accepted data bits in the current frame.
- States: IDLE, SHIFT, PAR (parity build only), HOLD.
- IDLE:
  - `s_ready`=1.
  - Accepted bits with `s_first`=0 are discarded.
  - An accepted bit with `s_first`=1 is shifted in, `cnt`<=1, and the next state is SHIFT.
- SHIFT:
  - `s_ready`=1.
  - Each accepted bit is shifted in and `cnt` increments.
  - On the WIDTH-th bit, the next state is PAR if parity is compiled in, otherwise HOLD.
  - Resync: an accepted bit with `s_first`=1 while `cnt`>=1 discards the partial frame. That bit becomes bit 1 of a new frame (`cnt`<=1), `frame_drop` pulses for one cycle, and the state stays SHIFT.
  - The resync check takes priority over completion, so `s_first` on what would have been the WIDTH-th bit restarts the frame.
- PAR:
  - `s_ready`=1.
  - The next accepted bit is the parity bit and is not shifted in.
  - `p_err` <= XOR of data bits XOR parity bit (even parity).
  - Next state is HOLD.
  - `s_first` on the parity bit is treated as a resync: `frame_drop` pulses, the bit starts a new frame, and the state returns to SHIFT.
- HOLD:
  - `s_ready`=0, `p_valid`=1.
  - `p_data` and `p_err` are stable.
  - On `p_valid && p_ready`, the next state is IDLE.
  - `p_valid` must never drop without a handshake.
- `p_data` is driven from the shift register. It is guaranteed stable only while `p_valid`=1.

## Timing
- Reset values: state=IDLE, `shreg`=0, `cnt`=0. Outputs: `p_data`=0, `p_valid`=0, `p_err`=0, `frame_drop`=0, `busy`=0, `s_ready`=1.
- Reset asserted mid-frame or in HOLD discards all content immediately. No output handshake completes.
- `p_valid` rises at the same edge that accepts the last data bit (or the parity bit), so it is visible the following cycle.
- Minimum latency from accepting the first bit to `p_valid` is WIDTH cycles, or WIDTH+1 with parity.
- `s_ready` is low from the edge that sets `p_valid` through the handshake cycle. It is high again in the cycle after `p_ready` is sampled; there is no bypass.
- Maximum throughput: one word per WIDTH+1 cycles, or WIDTH+2 with parity, with `p_ready` tied high.
- `s_ready`, `p_valid` and `busy` are decoded from registered state only; there is no combinational path from `p_ready` or `s_valid`.

## Configuration
- Macro: `SIPO_FRAME_PARITY_EN`.
- Defined:
  - The PAR state exists and one even-parity bit follows every WIDTH data bits.
  - `p_err` is registered as described in PAR.
- Undefined:
  - There is no PAR state; SHIFT goes directly to HOLD.
  - `p_err` is tied to 0.
  - A frame is exactly WIDTH bits.

## Test plan
- WIDTH=4, parity off: bits 1,0,1,1 with `s_first` on the first bit, `s_valid` continuous, `p_ready`=1. Expect `p_data`=4'b1011 and `p_valid`=1 for exactly one cycle, with `s_ready`=0 in that cycle.
- Bits 1,1 with `s_first`=0 in IDLE, then frame 0,1,1,0 -> `p_data`=4'b0110; the leading bits are discarded.
- Backpressure: complete frame 4'b1100, hold `p_ready`=0 for 5 cycles while `s_valid`=1 -> `p_valid` and `p_data` are stable, `s_ready`=0 throughout, and no bits are accepted. Then release `p_ready`: `s_ready`=1 in the following cycle.
- Resync: bits 1,0 followed by `s_first` with bits 0,0,1,1 -> `frame_drop` pulses once and `p_data`=4'b0011.
- Parity on: data 1,0,1,1 with parity 1 -> `p_err`=0; with parity 0 -> `p_err`=1; `p_valid` arrives one cycle later than with parity off.
- Assert `rst` in HOLD and mid-SHIFT -> all outputs return to reset values immediately. A new frame 1,1,1,1 then yields 4'b1111.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Framed serial-in/parallel-out capture controller with valid/ready on both sides.
// Optional even-parity check compiled in with `define SIPO_FRAME_PARITY_EN.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_data,
  input  logic             s_first,
  output logic             s_ready,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             p_err,
  output logic             frame_drop,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef SIPO_FRAME_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             drop_q, drop_n;
  logic             acc;
`ifdef SIPO_FRAME_PARITY_EN
  logic             err_q, err_n;
`endif

  // Handshake outputs decode registered state only.
  assign s_ready    = (state != HOLD);
  assign p_valid    = (state == HOLD);
  assign busy       = (state != IDLE);
  assign p_data     = shreg;
  assign frame_drop = drop_q;
  assign acc        = s_valid && s_ready;

`ifdef SIPO_FRAME_PARITY_EN
  assign p_err = err_q;
`else
  assign p_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    drop_n  = 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
    err_n   = err_q;
`endif
    case (state)
      IDLE: begin
        if (acc && s_first) begin
          shreg_n = {{(WIDTH-1){1'b0}}, s_data};
          cnt_n   = CNT_ONE;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (acc) begin
          // Resync wins over completion: a first-bit marker always restarts.
          if (s_first) begin
            shreg_n = {{(WIDTH-1){1'b0}}, s_data};
            cnt_n   = CNT_ONE;
            drop_n  = 1'b1;
          end else begin
            shreg_n = {shreg[WIDTH-2:0], s_data};
            cnt_n   = cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
`ifdef SIPO_FRAME_PARITY_EN
              state_n = PAR;
`else
              state_n = HOLD;
`endif
            end
          end
        end
      end
`ifdef SIPO_FRAME_PARITY_EN
      PAR: begin
        if (acc) begin
          if (s_first) begin
            shreg_n = {{(WIDTH-1){1'b0}}, s_data};
            cnt_n   = CNT_ONE;
            drop_n  = 1'b1;
            state_n = SHIFT;
          end else begin
            err_n   = (^shreg) ^ s_data;
            state_n = HOLD;
          end
        end
      end
`endif
      HOLD: begin
        if (p_ready) begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      drop_q <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      cnt    <= cnt_n;
      drop_q <= drop_n;
`ifdef SIPO_FRAME_PARITY_EN
      err_q  <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Randomized + directed bench for sipo_frame_ctrl against a queue-based frame model.
module tb_sipo_frame_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0, s_data = 1'b0, s_first = 1'b0;
  logic         s_ready;
  logic [W-1:0] p_data;
  logic         p_valid;
  logic         p_ready = 1'b1;
  logic         p_err, frame_drop, busy;

  int n_chk  = 0;
  int n_fail = 0;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_first(s_first), .s_ready(s_ready),
    .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready), .p_err(p_err),
    .frame_drop(frame_drop), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: bits of the frame in progress, plus the completed word being offered.
  bit           q[$];
  logic [W-1:0] word = '0;
  bit           holding = 0, awaiting = 0, m_err = 0, m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    m_drop = 0;
    if (holding) begin
      if (p_ready) holding = 0;
    end else if (s_valid) begin
      if (s_first) begin
        if (q.size() > 0 || awaiting) m_drop = 1;
        q.delete();
        q.push_back(s_data);
        awaiting = 0;
      end else if (awaiting) begin
        m_err    = (^word) ^ s_data;
        awaiting = 0;
        holding  = 1;
      end else if (q.size() > 0) begin
        q.push_back(s_data);
        if (q.size() == W) begin
          word = '0;
          foreach (q[i]) word = {word[W-2:0], q[i]};
          q.delete();
`ifdef SIPO_FRAME_PARITY_EN
          awaiting = 1;
`else
          holding = 1;
`endif
        end
      end
    end
  endtask

  task automatic check_outs();
    chk("s_ready", s_ready, !holding);
    chk("p_valid", p_valid, holding);
    chk("busy", busy, (q.size() > 0) || awaiting || holding);
    chk("frame_drop", frame_drop, m_drop);
    if (holding) begin
      chk("p_data", p_data, word);
      chk("p_err", p_err, m_err);
    end
  endtask

  task automatic cycle(input logic v, input logic d, input logic f, input logic pr);
    @(negedge clk);
    s_valid = v; s_data = d; s_first = f; p_ready = pr;
    @(posedge clk);
    model_step();
    #1 check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic par, input logic pr);
    for (int i = W - 1; i >= 0; i--) cycle(1'b1, w[i], (i == W - 1), pr);
`ifdef SIPO_FRAME_PARITY_EN
    cycle(1'b1, par, 1'b0, pr);
`else
    if (par === 1'bx) $display("note: parity bit unused");
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 0; s_first = 0; s_data = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_p_data", p_data, '0);
    chk("rst_p_valid", p_valid, 1'b0);
    chk("rst_p_err", p_err, 1'b0);
    chk("rst_frame_drop", frame_drop, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    q.delete(); holding = 0; awaiting = 0; m_err = 0; m_drop = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    // basic frame 1011
    send_frame(4'b1011, 1'b1, 1'b1);
    idle(2);
    // leading non-first bits discarded
    cycle(1, 1, 0, 1); cycle(1, 1, 0, 1);
    send_frame(4'b0110, 1'b0, 1'b1);
    idle(2);
    // backpressure with s_valid held high
    send_frame(4'b1100, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    idle(2);
    // resync mid-frame
    cycle(1, 1, 1, 1); cycle(1, 0, 0, 1);
    send_frame(4'b0011, 1'b0, 1'b1);
    idle(2);
    // parity good / bad
    send_frame(4'b1011, 1'b1, 1'b1);
    idle(2);
    send_frame(4'b1011, 1'b0, 1'b1);
    idle(2);
    // reset in HOLD, then mid-SHIFT, then a clean frame
    send_frame(4'b1010, 1'b0, 1'b0);
    do_reset();
    cycle(1, 1, 1, 1); cycle(1, 0, 0, 1);
    do_reset();
    send_frame(4'b1111, 1'b0, 1'b1);
    idle(2);
    // random traffic
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) < 3));
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
